rc4_host_port: RTL and testbench

//  Host-side responder for the RC4 core's byte-stream interface; the synthesizable counterpart of the bench driver.

---
 rtl/rc4_host_pkg.sv | 26 ++
 rtl/rc4_host_ram.sv | 29 ++
 rtl/rc4_host_port.sv | 224 ++++++++++++++++++++++
 tb/tb_rc4_host_port.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_host_pkg.sv
// Shared constants, state encoding and select encodings for the RC4 host port.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package rc4_host_pkg;

  localparam int DEPTH   = 2048;  // bytes per plain/cipher buffer
  localparam int AW      = 11;    // log2(DEPTH)
  localparam int KEY_MAX = 32;    // key buffer size in bytes

  // cfg_sel encodings
  localparam logic CFG_SEL_KEY   = 1'b0;
  localparam logic CFG_SEL_PLAIN = 1'b1;

  // rd_sel encodings
  localparam logic RD_SEL_PLAIN  = 1'b0;
  localparam logic RD_SEL_CIPHER = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_PLAIN,
    ST_CIPHER,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rc4_host_ram.sv
// Byte array with one synchronous write port and two asynchronous read ports.
// Latency: write lands on the clock edge; reads are combinational.
// Backpressure: none; every write strobe is accepted.
module rc4_host_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem [0:(1<<AW)-1];

  // Single write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/rc4_host_port.sv
// Host-side responder for the RC4 core: streams the key, serves plain/cipher reads, captures core output.
// Latency: stream outputs and rd_data are registered, valid one cycle after the request/address.
// Backpressure: a read request coinciding with its own write strobe is not serviced; the core re-asserts it.
module rc4_host_port
  import rc4_host_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [7:0]    cfg_wdata,
  input  logic [5:0]    key_len,
  input  logic [AW:0]   plain_len,
  input  logic          start,
  output logic          busy,
  output logic          finished,
  output logic [AW:0]   err_cnt,
  output logic          ovf,
  input  logic          rd_sel,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          key_valid,
  output logic [7:0]    key_in,
  input  logic          plain_read,
  output logic          plain_in_valid,
  output logic [7:0]    plain_in,
  input  logic          plain_write,
  input  logic [7:0]    plain_out,
  input  logic          cipher_write,
  input  logic [7:0]    cipher_out,
  input  logic          cipher_read,
  output logic          cipher_in_valid,
  output logic [7:0]    cipher_in,
  input  logic          done
);

  localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

  state_t      state;
  logic [5:0]  key_len_q;
  logic [AW:0] plain_len_q;
  logic [5:0]  kp;
  logic [AW:0] pr, pw, cr, cw;

  logic [7:0]  key_buf [KEY_MAX];

  logic        cfg_open;
  logic        plain_cfg_we;
  logic        capp_we, capc_we;
  logic [7:0]  plain_at_pr, plain_at_pw;
  logic [7:0]  capp_rd_a, capp_rd_unused;
  logic [7:0]  capc_at_cr, capc_rd_b;

  assign busy     = (state == ST_KEY) || (state == ST_PLAIN) || (state == ST_CIPHER);
  assign cfg_open = (state == ST_IDLE) || (state == ST_DONE);

  assign plain_cfg_we = cfg_open && cfg_we && (cfg_sel == CFG_SEL_PLAIN);
  // Saturated pointers drop the write; the FSM block raises ovf for it.
  assign capp_we = busy && plain_write  && (pw != PTR_FULL);
  assign capc_we = busy && cipher_write && (cw != PTR_FULL);

  // Original plaintext: port a feeds the read stream, port b the round-trip compare.
  rc4_host_ram #(.AW(AW)) u_plain (
    .clk     (clk),
    .we      (plain_cfg_we),
    .waddr   (cfg_addr),
    .wdata   (cfg_wdata),
    .raddr_a (pr[AW-1:0]),
    .rdata_a (plain_at_pr),
    .raddr_b (pw[AW-1:0]),
    .rdata_b (plain_at_pw)
  );

  // Captured decrypted plaintext, only read back by the host.
  rc4_host_ram #(.AW(AW)) u_capp (
    .clk     (clk),
    .we      (capp_we),
    .waddr   (pw[AW-1:0]),
    .wdata   (plain_out),
    .raddr_a (rd_addr),
    .rdata_a (capp_rd_a),
    .raddr_b (rd_addr),
    .rdata_b (capp_rd_unused)
  );

  // Captured ciphertext: port a replays it to the core, port b serves readback.
  rc4_host_ram #(.AW(AW)) u_capc (
    .clk     (clk),
    .we      (capc_we),
    .waddr   (cw[AW-1:0]),
    .wdata   (cipher_out),
    .raddr_a (cr[AW-1:0]),
    .rdata_a (capc_at_cr),
    .raddr_b (rd_addr),
    .rdata_b (capc_rd_b)
  );

  // Key buffer writes; open only between runs, contents survive reset.
  always_ff @(posedge clk) begin
    if (cfg_open && cfg_we && (cfg_sel == CFG_SEL_KEY)) begin
      key_buf[cfg_addr[4:0]] <= cfg_wdata;
    end
  end

  // Run sequencing, stream responses and capture bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      key_len_q       <= '0;
      plain_len_q     <= '0;
      kp              <= '0;
      pr              <= '0;
      pw              <= '0;
      cr              <= '0;
      cw              <= '0;
      err_cnt         <= '0;
      ovf             <= 1'b0;
      finished        <= 1'b0;
      key_valid       <= 1'b0;
      key_in          <= '0;
      plain_in_valid  <= 1'b0;
      plain_in        <= '0;
      cipher_in_valid <= 1'b0;
      cipher_in       <= '0;
    end else begin
      // Capture runs alongside the stream FSM while a run is active.
      if (busy) begin
        if (plain_write) begin
          if (pw == PTR_FULL) begin
            ovf <= 1'b1;
          end else begin
            pw <= pw + 1'b1;
            if (plain_out != plain_at_pw) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        if (cipher_write) begin
          if (cw == PTR_FULL) begin
            ovf <= 1'b1;
          end else begin
            cw <= cw + 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && (key_len != 6'd0)) begin
            key_len_q       <= key_len;
            plain_len_q     <= plain_len;
            kp              <= '0;
            pr              <= '0;
            pw              <= '0;
            cr              <= '0;
            cw              <= '0;
            err_cnt         <= '0;
            ovf             <= 1'b0;
            finished        <= 1'b0;
            plain_in_valid  <= 1'b0;
            plain_in        <= '0;
            cipher_in_valid <= 1'b0;
            cipher_in       <= '0;
            state           <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (kp < key_len_q) begin
            key_valid <= 1'b1;
            key_in    <= key_buf[kp[4:0]];
            kp        <= kp + 1'b1;
          end else begin
            key_valid <= 1'b0;
            key_in    <= '0;
            state     <= ST_PLAIN;
          end
        end
        ST_PLAIN: begin
          if (done) begin
            finished <= 1'b1;
            state    <= ST_DONE;
          end else if (plain_read && !plain_write) begin
            if (pr < plain_len_q) begin
              plain_in       <= plain_at_pr;
              plain_in_valid <= 1'b1;
            end else begin
              plain_in       <= '0;
              plain_in_valid <= 1'b0;
              state          <= ST_CIPHER;
            end
            pr <= pr + 1'b1;
          end
        end
        ST_CIPHER: begin
          if (done) begin
            finished <= 1'b1;
            state    <= ST_DONE;
          end else if (cipher_read && !cipher_write) begin
            if (cr < plain_len_q) begin
              cipher_in       <= capc_at_cr;
              cipher_in_valid <= 1'b1;
            end else begin
              cipher_in       <= '0;
              cipher_in_valid <= 1'b0;
            end
            cr <= cr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered readback of either capture buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= (rd_sel == RD_SEL_CIPHER) ? capc_rd_b : capp_rd_a;
    end
  end

endmodule

// File: tb/tb_rc4_host_port.sv
// Directed bench for rc4_host_port, with a behavioural RC4 core driving the stream side.
// Latency: samples 1 time unit after each rising edge, drives inputs at the same point.
// Backpressure: bench core waits on DUT responses with bounded loops.
`timescale 1ns/1ps
module tb_rc4_host_port;
  import rc4_host_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we, cfg_sel;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_wdata;
  logic [5:0]    key_len;
  logic [AW:0]   plain_len;
  logic          start;
  logic          busy, finished, ovf;
  logic [AW:0]   err_cnt;
  logic          rd_sel;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          key_valid;
  logic [7:0]    key_in;
  logic          plain_read, plain_in_valid, plain_write;
  logic [7:0]    plain_in, plain_out;
  logic          cipher_write, cipher_read, cipher_in_valid;
  logic [7:0]    cipher_out, cipher_in;
  logic          done;

  always #5 clk = ~clk;

  rc4_host_port dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .key_len(key_len), .plain_len(plain_len), .start(start),
    .busy(busy), .finished(finished), .err_cnt(err_cnt), .ovf(ovf),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .key_valid(key_valid), .key_in(key_in),
    .plain_read(plain_read), .plain_in_valid(plain_in_valid), .plain_in(plain_in),
    .plain_write(plain_write), .plain_out(plain_out),
    .cipher_write(cipher_write), .cipher_out(cipher_out),
    .cipher_read(cipher_read), .cipher_in_valid(cipher_in_valid), .cipher_in(cipher_in),
    .done(done)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_cipher [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] plain_txt  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] key_txt    [5] = '{8'h4B, 8'h65, 8'h79, 8'hA5, 8'h5A};

  logic [7:0] got_key [KEY_MAX];
  int         got_kcnt;
  int         S [256];
  int         ri, rj;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input int addr, input logic [7:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr[AW-1:0]; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int kl, input int pl);
    key_len = kl[5:0]; plain_len = pl[AW:0]; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic readback(input logic sel, input int addr, output logic [7:0] d);
    rd_sel = sel; rd_addr = addr[AW-1:0];
    tick();
    d = rd_data;
  endtask

  task automatic finish_run();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Reference RC4 key schedule over the key bytes the DUT actually streamed.
  task automatic ksa(input int klen_in);
    int j, t, klen;
    klen = (klen_in == 0) ? 1 : klen_in;
    for (int i = 0; i < 256; i++) S[i] = i;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + S[i] + int'(got_key[i % klen])) & 255;
      t = S[i]; S[i] = S[j]; S[j] = t;
    end
    ri = 0; rj = 0;
  endtask

  task automatic prga(output logic [7:0] k);
    int t;
    ri = (ri + 1) & 255;
    rj = (rj + S[ri]) & 255;
    t = S[ri]; S[ri] = S[rj]; S[rj] = t;
    k = 8'(S[(S[ri] + S[rj]) & 255]);
  endtask

  task automatic collect_key();
    bit fin;
    fin = 1'b0;
    got_kcnt = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      tick();
      if (key_valid === 1'b1) begin
        if (got_kcnt < KEY_MAX) got_key[got_kcnt] = key_in;
        got_kcnt++;
      end else if (got_kcnt > 0) begin
        fin = 1'b1;
      end
    end
    if (!fin) begin
      total++;
      $display("FAIL key_stream_timeout got %0d bytes, key_valid never fell", got_kcnt);
    end
  endtask

  task automatic enc_phase();
    bit ended;
    logic [7:0] k;
    ended = 1'b0;
    ksa(got_kcnt);
    for (int c = 0; c < 40 && !ended; c++) begin
      plain_read = 1'b1;
      tick();
      plain_read = 1'b0;
      if (plain_in_valid === 1'b1) begin
        prga(k);
        cipher_out = plain_in ^ k; cipher_write = 1'b1;
        tick();
        cipher_write = 1'b0;
      end else begin
        ended = 1'b1;
      end
    end
    if (!ended) begin
      total++;
      $display("FAIL plain_stream_timeout end of stream not seen");
    end
  endtask

  task automatic dec_phase(input int corrupt);
    bit ended;
    int n;
    logic [7:0] k;
    ended = 1'b0; n = 0;
    ksa(got_kcnt);
    for (int c = 0; c < 40 && !ended; c++) begin
      cipher_read = 1'b1;
      tick();
      cipher_read = 1'b0;
      if (cipher_in_valid === 1'b1) begin
        prga(k);
        plain_out = cipher_in ^ k ^ ((n == corrupt) ? 8'hFF : 8'h00);
        plain_write = 1'b1;
        tick();
        plain_write = 1'b0;
        n++;
      end else begin
        ended = 1'b1;
      end
    end
    if (!ended) begin
      total++;
      $display("FAIL cipher_stream_timeout end of stream not seen");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({busy, finished, ovf, key_valid, plain_in_valid, cipher_in_valid} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000",
               {busy, finished, ovf, key_valid, plain_in_valid, cipher_in_valid});
    else passed++;
    total++;
    if ({key_in, plain_in, cipher_in, rd_data} !== 32'h0)
      $display("FAIL reset_data got %h want 0", {key_in, plain_in, cipher_in, rd_data});
    else passed++;
    total++;
    if (err_cnt !== '0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic load_buffers();
    for (int i = 0; i < 3; i++) cfg_write(CFG_SEL_KEY, i, key_txt[i]);
    for (int i = 0; i < 9; i++) cfg_write(CFG_SEL_PLAIN, i, plain_txt[i]);
  endtask

  task automatic test_roundtrip(input string tag);
    logic [7:0] d;
    do_start(3, 9);
    collect_key();
    total++;
    if (got_kcnt != 3) $display("FAIL %s_key_cycles got %0d want 3", tag, got_kcnt);
    else passed++;
    enc_phase();
    dec_phase(-1);
    finish_run();
    total++;
    if (finished !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_done got finished=%b busy=%b want 1 0", tag, finished, busy);
    else passed++;
    total++;
    if (err_cnt !== '0) $display("FAIL %s_err_cnt got %0d want 0", tag, err_cnt);
    else passed++;
    for (int i = 0; i < 9; i++) begin
      readback(RD_SEL_CIPHER, i, d);
      total++;
      if (d !== exp_cipher[i]) $display("FAIL %s_cipher[%0d] got %h want %h", tag, i, d, exp_cipher[i]);
      else passed++;
      readback(RD_SEL_PLAIN, i, d);
      total++;
      if (d !== plain_txt[i]) $display("FAIL %s_capp[%0d] got %h want %h", tag, i, d, plain_txt[i]);
      else passed++;
    end
  endtask

  task automatic test_key_len5();
    cfg_write(CFG_SEL_KEY, 3, key_txt[3]);
    // Last key byte written in the same cycle as start.
    cfg_we = 1'b1; cfg_sel = CFG_SEL_KEY; cfg_addr = 4; cfg_wdata = key_txt[4];
    do_start(5, 0);
    cfg_we = 1'b0;
    total++;
    if (finished !== 1'b0 || busy !== 1'b1)
      $display("FAIL k5_start got finished=%b busy=%b want 0 1", finished, busy);
    else passed++;
    collect_key();
    total++;
    if (got_kcnt != 5) $display("FAIL k5_key_cycles got %0d want 5", got_kcnt);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_key[i] !== key_txt[i]) $display("FAIL k5_key[%0d] got %h want %h", i, got_key[i], key_txt[i]);
      else passed++;
    end
    total++;
    if (key_valid !== 1'b0 || key_in !== 8'h00)
      $display("FAIL k5_key_idle got valid=%b key_in=%h want 0 00", key_valid, key_in);
    else passed++;
    plain_read = 1'b1; tick(); plain_read = 1'b0;
    total++;
    if (plain_in_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL p0_plain_end got valid=%b busy=%b want 0 1", plain_in_valid, busy);
    else passed++;
    cipher_read = 1'b1; tick(); cipher_read = 1'b0;
    total++;
    if (cipher_in_valid !== 1'b0 || cipher_in !== 8'h00)
      $display("FAIL p0_cipher_end got valid=%b data=%h want 0 00", cipher_in_valid, cipher_in);
    else passed++;
    finish_run();
    total++;
    if (finished !== 1'b1) $display("FAIL p0_finished got %b want 1", finished);
    else passed++;
  endtask

  task automatic test_corrupt();
    logic [7:0] d;
    do_start(3, 9);
    collect_key();
    enc_phase();
    dec_phase(3);
    finish_run();
    total++;
    if (err_cnt !== (AW+1)'(1)) $display("FAIL corrupt_err_cnt got %0d want 1", err_cnt);
    else passed++;
    readback(RD_SEL_PLAIN, 3, d);
    total++;
    if (d !== 8'h96) $display("FAIL corrupt_capp3 got %h want 96", d);
    else passed++;
    readback(RD_SEL_PLAIN, 2, d);
    total++;
    if (d !== 8'h61) $display("FAIL corrupt_capp2 got %h want 61", d);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_start(3, 9);
    collect_key();
    plain_read = 1'b1; tick(); plain_read = 1'b0;
    total++;
    if (plain_in_valid !== 1'b1 || plain_in !== 8'h50)
      $display("FAIL rw_first got valid=%b data=%h want 1 50", plain_in_valid, plain_in);
    else passed++;
    plain_read = 1'b1; plain_write = 1'b1; plain_out = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (plain_in !== 8'h50) $display("FAIL rw_hold[%0d] got %h want 50", c, plain_in);
      else passed++;
    end
    plain_read = 1'b0; plain_write = 1'b0;
    total++;
    if (err_cnt !== (AW+1)'(3)) $display("FAIL rw_err_cnt got %0d want 3", err_cnt);
    else passed++;
    plain_read = 1'b1; tick(); plain_read = 1'b0;
    total++;
    if (plain_in !== 8'h6C) $display("FAIL rw_next got %h want 6c", plain_in);
    else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      cipher_write = 1'b1; cipher_out = i[7:0];
      tick();
    end
    cipher_write = 1'b0;
    total++;
    if (ovf !== 1'b0) $display("FAIL ovf_at_depth got %b want 0", ovf);
    else passed++;
    cipher_write = 1'b1; cipher_out = 8'hAB; tick(); cipher_write = 1'b0;
    total++;
    if (ovf !== 1'b1) $display("FAIL ovf_past_depth got %b want 1", ovf);
    else passed++;
    readback(RD_SEL_CIPHER, 0, d);
    total++;
    if (d !== 8'h00) $display("FAIL ovf_no_wrap got %h want 00", d);
    else passed++;
    readback(RD_SEL_CIPHER, DEPTH - 1, d);
    total++;
    if (d !== 8'hFF) $display("FAIL ovf_last got %h want ff", d);
    else passed++;
    readback(RD_SEL_CIPHER, 1000, d);
    total++;
    if (d !== 8'hE8) $display("FAIL ovf_mid got %h want e8", d);
    else passed++;
    finish_run();
  endtask

  task automatic test_rst_mid();
    do_start(3, 9);
    total++;
    if (ovf !== 1'b0) $display("FAIL start_clears_ovf got %b want 0", ovf);
    else passed++;
    collect_key();
    plain_read = 1'b1; tick(); plain_read = 1'b0;
    plain_read = 1'b1; tick(); plain_read = 1'b0;
    total++;
    if (plain_in_valid !== 1'b1 || plain_in !== 8'h6C)
      $display("FAIL rst_pre got valid=%b data=%h want 1 6c", plain_in_valid, plain_in);
    else passed++;
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({busy, finished, key_valid, plain_in_valid, plain_in, err_cnt} !== '0)
      $display("FAIL rst_mid got busy=%b fin=%b kv=%b piv=%b pin=%h err=%0d want all 0",
               busy, finished, key_valid, plain_in_valid, plain_in, err_cnt);
    else passed++;
    plain_read = 1'b1; tick(); plain_read = 1'b0;
    total++;
    if (plain_in_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_idle_read got valid=%b busy=%b want 0 0", plain_in_valid, busy);
    else passed++;
    test_roundtrip("rerun");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    key_len = '0; plain_len = '0; start = 1'b0; rd_sel = 1'b0; rd_addr = '0;
    plain_read = 1'b0; plain_write = 1'b0; plain_out = '0;
    cipher_write = 1'b0; cipher_out = '0; cipher_read = 1'b0; done = 1'b0;
    test_reset();
    load_buffers();
    test_roundtrip("rt");
    test_key_len5();
    test_corrupt();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
